// File: rtl/alu_seq.sv
// alu_seq: parametrised, handshaked ALU.
// Single-cycle arithmetic, logic and compare operations complete at the accept edge.
// Shifts (by n > 0) and unsigned multiply run iteratively and are framed by busy/alu_done.
// Y and the flags hold their last value between operations; alu_done is a one-cycle pulse.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             incoming,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       operator,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             signov,
    output logic             zero,
    output logic             busy,
    output logic             alu_done
);

    localparam int SW = $clog2(WIDTH);
    // The counter must reach WIDTH for multiply, so it gets one bit more than the shift field.
    localparam int CW = SW + 1;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_MUL   = 2'd2;

    // Opcodes
    localparam logic [3:0] OP_ADDU = 4'd0;
    localparam logic [3:0] OP_SUBU = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_EQ   = 4'd9;
    localparam logic [3:0] OP_ADDS = 4'd10;
    localparam logic [3:0] OP_SUBS = 4'd11;
    localparam logic [3:0] OP_MULU = 4'd12;
    localparam logic [3:0] OP_SLTS = 4'd13;

    // Registered state
    logic [1:0]         state_q,  state_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [3:0]         op_q,     op_d;
    // work_q: shift register (low half) during SHIFT, running product during MUL
    logic [2*WIDTH-1:0] work_q,   work_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   y_q,      y_d;
    logic               carry_q,  carry_d;
    logic               signov_q, signov_d;
    logic               zero_q,   zero_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    // Combinational helpers
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   res_y_s;
    logic               res_c_s;
    logic               res_v_s;
    logic [SW-1:0]      shamt_s;
    logic               accept_s;
    logic [WIDTH-1:0]   sh_next_s;
    logic               sh_out_s;
    logic [2*WIDTH-1:0] prod_next_s;

    assign shamt_s  = B[SW-1:0];
    assign accept_s = incoming && (state_q == ST_IDLE);

    // Single-cycle result and flags computed directly from the live operands
    always_comb begin
        sum_s   = {1'b0, A} + {1'b0, B};
        diff_s  = {1'b0, A} - {1'b0, B};
        res_y_s = {WIDTH{1'b0}};
        res_c_s = 1'b0;
        res_v_s = 1'b0;
        case (operator)
            OP_ADDU: begin
                res_y_s = sum_s[WIDTH-1:0];
                res_c_s = sum_s[WIDTH];
            end
            OP_SUBU: begin
                res_y_s = diff_s[WIDTH-1:0];
                res_c_s = diff_s[WIDTH];
            end
            OP_AND:  res_y_s = A & B;
            OP_OR:   res_y_s = A | B;
            OP_NOT:  res_y_s = ~A;
            OP_XOR:  res_y_s = A ^ B;
            // Only a zero shift amount completes here; non-zero amounts go to SHIFT.
            OP_SHL:  res_y_s = A;
            OP_SHR:  res_y_s = A;
            OP_SLTU: res_y_s = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_EQ:   res_y_s = {{(WIDTH-1){1'b0}}, (A == B)};
            OP_ADDS: begin
                res_y_s = sum_s[WIDTH-1:0];
                res_c_s = sum_s[WIDTH];
                res_v_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUBS: begin
                res_y_s = diff_s[WIDTH-1:0];
                res_c_s = diff_s[WIDTH];
                res_v_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLTS: res_y_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            // MULU always goes multi-cycle; reserved opcodes return zero.
            default: begin
                res_y_s = {WIDTH{1'b0}};
                res_c_s = 1'b0;
                res_v_s = 1'b0;
            end
        endcase
    end

    // One shift step on the latched operand; direction follows the latched opcode
    always_comb begin
        if (op_q == OP_SHL) begin
            sh_next_s = {work_q[WIDTH-2:0], 1'b0};
            sh_out_s  = work_q[WIDTH-1];
        end else begin
            sh_next_s = {1'b0, work_q[WIDTH-1:1]};
            sh_out_s  = work_q[0];
        end
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        if (mplier_q[0]) begin
            prod_next_s = work_q + mcand_q;
        end else begin
            prod_next_s = work_q;
        end
    end

    // Next-state logic for the FSM, operand latches and visible outputs
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        work_d   = work_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        y_d      = y_q;
        carry_d  = carry_q;
        signov_d = signov_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d = operator;
                    if (((operator == OP_SHL) || (operator == OP_SHR)) && (shamt_s != {SW{1'b0}})) begin
                        state_d = ST_SHIFT;
                        cnt_d   = {1'b0, shamt_s};
                        work_d  = {{WIDTH{1'b0}}, A};
                        busy_d  = 1'b1;
                    end else if (operator == OP_MULU) begin
                        state_d  = ST_MUL;
                        cnt_d    = CNT_MUL;
                        work_d   = {(2*WIDTH){1'b0}};
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        busy_d   = 1'b1;
                    end else begin
                        y_d      = res_y_s;
                        carry_d  = res_c_s;
                        signov_d = res_v_s;
                        zero_d   = (res_y_s == {WIDTH{1'b0}});
                        done_d   = 1'b1;
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                work_d = {{WIDTH{1'b0}}, sh_next_s};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    y_d      = sh_next_s;
                    carry_d  = sh_out_s;
                    signov_d = 1'b0;
                    zero_d   = (sh_next_s == {WIDTH{1'b0}});
                    done_d   = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_MUL: begin
                work_d   = prod_next_s;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    y_d      = prod_next_s[WIDTH-1:0];
                    carry_d  = (prod_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                    signov_d = 1'b0;
                    zero_d   = (prod_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    done_d   = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE without producing a result.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 4'd0;
            work_q   <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            y_q      <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            signov_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            work_q   <= work_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            y_q      <= y_d;
            carry_q  <= carry_d;
            signov_q <= signov_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Y        = y_q;
    assign carry    = carry_q;
    assign signov   = signov_q;
    assign zero     = zero_q;
    assign busy     = busy_q;
    assign alu_done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=16) with a queue-based scoreboard.
// Stimulus pushes the hand-computed expected result; the monitor pops on every alu_done.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        incoming;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  operator;
    logic [15:0] Y;
    logic        carry;
    logic        signov;
    logic        zero;
    logic        busy;
    logic        alu_done;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    typedef struct {
        string       nm;
        logic [15:0] y;
        logic        c;
        logic        v;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .incoming (incoming),
        .A        (A),
        .B        (B),
        .operator (operator),
        .Y        (Y),
        .carry    (carry),
        .signov   (signov),
        .zero     (zero),
        .busy     (busy),
        .alu_done (alu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter used to measure accept-to-done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // monitor: compare every presented result with the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && alu_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got alu_done=1 expected no result (Y=0x%0h)", Y);
            end else begin
                e = sb.pop_front();
                chk({e.nm, "_Y"},      32'(Y),      32'(e.y));
                chk({e.nm, "_carry"},  32'(carry),  32'(e.c));
                chk({e.nm, "_signov"}, 32'(signov), 32'(e.v));
                chk({e.nm, "_zero"},   32'(zero),   32'(e.z));
                chk({e.nm, "_busy"},   32'(busy),   32'd0);
                chk({e.nm, "_lat"},    32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic push(input string nm, input logic [15:0] ey, input logic ec,
                        input logic ev, input logic ez, input int lat);
        exp_t e;
        e.nm = nm; e.y = ey; e.c = ec; e.v = ev; e.z = ez; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL %s_timeout: got no alu_done expected one within 100 cycles", nm);
            sb.delete();
        end
    endtask

    // issue one operation, record its expectation, and wait for the result
    task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ey, input logic ec,
                         input logic ev, input logic ez, input int lat);
        @(negedge clk);
        operator = op; A = a; B = b; incoming = 1'b1;
        @(posedge clk);
        #1;
        incoming = 1'b0;
        push(nm, ey, ec, ev, ez, lat);
        if (lat > 1) begin
            @(negedge clk);
            chk({nm, "_busy_on"}, 32'(busy), 32'd1);
        end
        wait_idle(nm);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; incoming = 1'b0; A = 16'h0; B = 16'h0; operator = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_Y", 32'(Y), 32'd0);
        chk("rst_flags", {28'd0, carry, signov, zero, busy}, 32'd0);
        chk("rst_done", 32'(alu_done), 32'd0);
        rst_n = 1'b1;

        //      name     op     A         B         Y         c     v     z     lat
        issue("addu",  4'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1);
        issue("adds",  4'd10, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1);
        issue("subs",  4'd11, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1);
        issue("subu",  4'd1,  16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        issue("and",   4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1);
        issue("or",    4'd3,  16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1);
        issue("xor",   4'd5,  16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        issue("not",   4'd4,  16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 1);
        issue("shl4",  4'd6,  16'h8001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0, 5);
        issue("shr1",  4'd7,  16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 2);
        issue("shl0",  4'd6,  16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1);
        issue("shlhi", 4'd6,  16'h0001, 16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        issue("shr15", 4'd7,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 16);
        issue("mul1",  4'd12, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 17);
        issue("slts",  4'd13, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        issue("sltu",  4'd8,  16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        issue("eq",    4'd9,  16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        issue("rsv15", 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        issue("rsv14", 4'd14, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        issue("mulff", 4'd12, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 17);

        // back-to-back single-cycle accepts
        @(negedge clk);
        operator = 4'd0; A = 16'h0001; B = 16'h0002; incoming = 1'b1;
        @(posedge clk);
        #1;
        push("b2b_addu", 16'h0003, 1'b0, 1'b0, 1'b0, 1);
        operator = 4'd1; A = 16'h0005; B = 16'h0005;
        @(posedge clk);
        #1;
        incoming = 1'b0;
        push("b2b_subu", 16'h0000, 1'b0, 1'b0, 1'b1, 1);
        wait_idle("b2b");

        // request during MULU is ignored; latched operands are unaffected
        @(negedge clk);
        operator = 4'd12; A = 16'h0003; B = 16'h0005; incoming = 1'b1;
        @(posedge clk);
        #1;
        incoming = 1'b0;
        push("mul_ign", 16'h000F, 1'b0, 1'b0, 1'b0, 17);
        repeat (2) @(posedge clk);
        #1;
        operator = 4'd0; A = 16'h0001; B = 16'h0001; incoming = 1'b1;
        @(posedge clk);
        #1;
        incoming = 1'b0;
        wait_idle("mul_ign");
        repeat (3) @(negedge clk);

        // make flags non-zero, then reset in the middle of a multiply
        issue("mulc",  4'd12, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 17);
        @(negedge clk);
        operator = 4'd12; A = 16'h0100; B = 16'h0003; incoming = 1'b1;
        @(posedge clk);
        #1;
        incoming = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_Y", 32'(Y), 32'd0);
        chk("midrst_flags", {28'd0, carry, signov, zero, busy}, 32'd0);
        chk("midrst_done", 32'(alu_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_Y_hold", 32'(Y), 32'd0);
        issue("post_rst", 4'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
